// File: rtl/logic_unit_seq_if.sv
// Bus bundle for logic_unit_seq: start/abort request, operands and the registered result.
// Optional zflag appears only when LU_ZERO_FLAG_EN is defined.
interface logic_unit_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             abort;
  logic [2:0]       op;
  logic [WIDTH-1:0] regA;
  logic [WIDTH-1:0] regB;
  logic [WIDTH-1:0] regZ;
  logic             busy;
  logic             done;
`ifdef LU_ZERO_FLAG_EN
  logic             zflag;

  modport master (output start, abort, op, regA, regB,
                  input  regZ, busy, done, zflag);
  modport slave  (input  start, abort, op, regA, regB,
                  output regZ, busy, done, zflag);
`else
  modport master (output start, abort, op, regA, regB,
                  input  regZ, busy, done);
  modport slave  (input  start, abort, op, regA, regB,
                  output regZ, busy, done);
`endif
endinterface

// File: rtl/logic_unit_seq.sv
// Multi-cycle bitwise logic unit: SLICE bits per cycle, LSB slice first, result held in regZ.
// Optional feature macro: LU_ZERO_FLAG_EN adds the registered zero flag output.
module logic_unit_seq #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8,
  parameter int CNTW  = 3
) (
  input  logic               clk,
  input  logic               clr,
  logic_unit_seq_if.slave    bus,
  output logic [1:0]         state_dbg
);
  // Handshake: start is accepted at an edge only in IDLE or DONE; busy is high for
  // exactly N cycles in RUN; done pulses one cycle; abort acts only in RUN.
  localparam int N = WIDTH / SLICE;
  localparam logic [CNTW-1:0] LAST = CNTW'(N - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, z_q, z_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] f_word;
  int               base;
`ifdef LU_ZERO_FLAG_EN
  logic             zflag_q, zflag_d;
`endif

  function automatic logic [WIDTH-1:0] logic_fn(input logic [2:0] sel,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    case (sel)
      3'b000:  logic_fn = a & b;
      3'b001:  logic_fn = a | b;
      3'b010:  logic_fn = a ^ b;
      3'b011:  logic_fn = ~(a | b);
      3'b100:  logic_fn = ~a;
      3'b101:  logic_fn = a & ~b;
      3'b110:  logic_fn = ~(a & b);
      default: logic_fn = ~(a ^ b);
    endcase
  endfunction

  // Whole-word function of the latched operands; only the current slice is committed.
  assign f_word = logic_fn(op_q, a_q, b_q);
  assign base   = int'(cnt_q) * SLICE;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    z_d     = z_q;
`ifdef LU_ZERO_FLAG_EN
    zflag_d = zflag_q;
`endif
    case (state_q)
      S_RUN: begin
        if (bus.abort) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          z_d     = '0;
`ifdef LU_ZERO_FLAG_EN
          zflag_d = 1'b0;
`endif
        end else begin
          z_d[base +: SLICE] = f_word[base +: SLICE];
          if (cnt_q == LAST) begin
            state_d = S_DONE;
            cnt_d   = '0;
`ifdef LU_ZERO_FLAG_EN
            zflag_d = (z_d == '0);
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        // IDLE and DONE share the accept path; DONE otherwise falls back to IDLE.
        if (bus.start) begin
          state_d = S_RUN;
          cnt_d   = '0;
          a_d     = bus.regA;
          b_d     = bus.regB;
          op_d    = bus.op;
          z_d     = '0;
`ifdef LU_ZERO_FLAG_EN
          zflag_d = 1'b0;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      z_q     <= '0;
`ifdef LU_ZERO_FLAG_EN
      zflag_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      z_q     <= z_d;
`ifdef LU_ZERO_FLAG_EN
      zflag_q <= zflag_d;
`endif
    end
  end

  assign bus.regZ  = z_q;
  assign bus.busy  = (state_q == S_RUN);
  assign bus.done  = (state_q == S_DONE);
  assign state_dbg = state_q;
`ifdef LU_ZERO_FLAG_EN
  assign bus.zflag = zflag_q;
`endif
endmodule
